// File: rtl/id_operand_fwd.sv
// id_operand_fwd
//   Decode-stage operand fetch, forwarding and hazard unit. Each of NUM_SRC
//   source ports compares its register address against NUM_FWD forwarding
//   stages (0 = youngest/EX, NUM_FWD-1 = oldest/WB). The youngest match wins.
//   If that stage's result is not ready yet, the port raises a hazard. The
//   block also owns the ID->EX register (operands + payload) with a
//   valid/ready/flush handshake, and a saturating hazard-stall counter.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready IF->ID handshake; in_flush mirrors out_flush
//   in_rs_addr/use    per-port source address and "real operand" flag
//   in_rf_rdata       per-port register file read data
//   in_payload        decoded control bundle, passed through unmodified
//   fwd_rd_*          per-stage write enable, rd address, ready flag, data
//   out_valid/ready   ID->EX handshake; out_flush kills the ID->EX slot
//   out_rs_data       registered forwarded operands
//   out_payload       registered payload
//   hz_stall          combinational hazard stall this cycle
//   stall_cnt(_clr)   saturating hazard-stall cycle counter and its clear

// Per-source-port forwarding mux and hazard detect.
module id_operand_fwd_src #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic                      rs_use,
    input  logic [XLEN-1:0]           rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_rd_write,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr,
    input  logic [NUM_FWD-1:0]        fwd_rd_ready,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_rd_wdata,
    output logic [XLEN-1:0]           data,
    output logic                      hazard
);
    logic            hit;
    logic            sel_rdy;
    logic [XLEN-1:0] sel_data;

    // Scan oldest to youngest so the youngest matching stage overwrites the
    // selection last. The ready flag comes only from that youngest match, so
    // a ready older stage can never mask a younger result still in flight.
    always_comb begin
        hit      = 1'b0;
        sel_rdy  = 1'b1;
        sel_data = rf_rdata;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (fwd_rd_write[j] && (fwd_rd_addr[j*REG_AW +: REG_AW] == rs_addr)
                && (rs_addr != '0)) begin
                hit      = 1'b1;
                sel_rdy  = fwd_rd_ready[j];
                sel_data = fwd_rd_wdata[j*XLEN +: XLEN];
            end
        end
    end

    // x0 always reads as zero, whatever the register file returns.
    assign data   = (rs_addr == '0) ? '0 : sel_data;
    assign hazard = rs_use & hit & ~sel_rdy;
endmodule

module id_operand_fwd #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 3,
    parameter int PAYLOAD_W = 96,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      in_flush,
    input  logic [NUM_SRC*REG_AW-1:0] in_rs_addr,
    input  logic [NUM_SRC-1:0]        in_rs_use,
    input  logic [NUM_SRC*XLEN-1:0]   in_rf_rdata,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [NUM_FWD-1:0]        fwd_rd_write,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr,
    input  logic [NUM_FWD-1:0]        fwd_rd_ready,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_rd_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      out_flush,
    output logic [NUM_SRC*XLEN-1:0]   out_rs_data,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic                      hz_stall,
    output logic [CNT_W-1:0]          stall_cnt,
    input  logic                      stall_cnt_clr
);
    logic [NUM_SRC-1:0][XLEN-1:0] src_data;
    logic [NUM_SRC-1:0]           hazard;
    logic                         live;
    logic                         go;
    logic                         adv;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        id_operand_fwd_src #(
            .XLEN    (XLEN),
            .REG_AW  (REG_AW),
            .NUM_FWD (NUM_FWD)
        ) u_src (
            .rs_addr      (in_rs_addr[k*REG_AW +: REG_AW]),
            .rs_use       (in_rs_use[k]),
            .rf_rdata     (in_rf_rdata[k*XLEN +: XLEN]),
            .fwd_rd_write (fwd_rd_write),
            .fwd_rd_addr  (fwd_rd_addr),
            .fwd_rd_ready (fwd_rd_ready),
            .fwd_rd_wdata (fwd_rd_wdata),
            .data         (src_data[k]),
            .hazard       (hazard[k])
        );
    end

    // An instruction that is being flushed is neither stalled nor moved on;
    // in_ready is high so IF may drop it this same cycle.
    assign live     = in_valid & ~out_flush;
    assign hz_stall = live & (|hazard);
    assign go       = live & ~hz_stall;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = ~live | (go & adv);
    assign in_flush = out_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (out_flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= go;
        end
    end

    // Datapath register is not reset; its contents are ignored while
    // out_valid is low. It holds while EX back-pressures.
    always_ff @(posedge clk) begin
        if (!out_flush && adv && go) begin
            out_rs_data <= src_data;
            out_payload <= in_payload;
        end
    end

    // Counts only hazard stalls. Back-pressure from EX is a separate cause
    // and is deliberately not counted.
    always_ff @(posedge clk) begin
        if (rst || stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (hz_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_operand_fwd.sv
module tb_id_operand_fwd;
    localparam int XLEN = 32, REG_AW = 5, NUM_SRC = 2, NUM_FWD = 3;
    localparam int PAYLOAD_W = 96, CNT_W = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid, in_ready, in_flush;
    logic [NUM_SRC*REG_AW-1:0] in_rs_addr;
    logic [NUM_SRC-1:0]        in_rs_use;
    logic [NUM_SRC*XLEN-1:0]   in_rf_rdata;
    logic [PAYLOAD_W-1:0]      in_payload;
    logic [NUM_FWD-1:0]        fwd_rd_write, fwd_rd_ready;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr;
    logic [NUM_FWD*XLEN-1:0]   fwd_rd_wdata;
    logic                      out_valid, out_ready, out_flush;
    logic [NUM_SRC*XLEN-1:0]   out_rs_data;
    logic [PAYLOAD_W-1:0]      out_payload;
    logic                      hz_stall;
    logic [CNT_W-1:0]          stall_cnt;
    logic                      stall_cnt_clr;

    typedef struct {
        logic [NUM_SRC*XLEN-1:0] data;
        logic [PAYLOAD_W-1:0]    payload;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;

    id_operand_fwd #(
        .XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
        .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_flush(in_flush), .in_rs_addr(in_rs_addr), .in_rs_use(in_rs_use),
        .in_rf_rdata(in_rf_rdata), .in_payload(in_payload),
        .fwd_rd_write(fwd_rd_write), .fwd_rd_addr(fwd_rd_addr),
        .fwd_rd_ready(fwd_rd_ready), .fwd_rd_wdata(fwd_rd_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_flush(out_flush),
        .out_rs_data(out_rs_data), .out_payload(out_payload),
        .hz_stall(hz_stall), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid      = 1'b0;
        in_rs_addr    = '0;
        in_rs_use     = '0;
        in_rf_rdata   = '0;
        in_payload    = '0;
        fwd_rd_write  = '0;
        fwd_rd_addr   = '0;
        fwd_rd_ready  = '1;
        fwd_rd_wdata  = '0;
        out_ready     = 1'b1;
        out_flush     = 1'b0;
        stall_cnt_clr = 1'b0;
    endtask

    task automatic set_src(input int k, input logic [REG_AW-1:0] a, input logic u,
                           input logic [XLEN-1:0] d);
        in_rs_addr[k*REG_AW +: REG_AW] = a;
        in_rs_use[k]                   = u;
        in_rf_rdata[k*XLEN +: XLEN]    = d;
    endtask

    task automatic set_fwd(input int j, input logic we, input logic [REG_AW-1:0] a,
                           input logic rdy, input logic [XLEN-1:0] d);
        fwd_rd_write[j]                = we;
        fwd_rd_addr[j*REG_AW +: REG_AW] = a;
        fwd_rd_ready[j]                = rdy;
        fwd_rd_wdata[j*XLEN +: XLEN]   = d;
    endtask

    task automatic new_payload;
        in_payload = {$urandom, $urandom, $urandom};
    endtask

    task automatic test_reset;
        idle();
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_regfile;
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd5, 1'b1, 32'h11);
        set_src(1, 5'd6, 1'b1, 32'h22);
        new_payload();
        e.data = {32'h22, 32'h11}; e.payload = in_payload; sb.push_back(e);
        #1;
        checks++;
        if (in_ready !== 1'b1 || hz_stall !== 1'b0) begin
            errors++; $display("FAIL rf_ready got=%0b/%0b exp=1/0", in_ready, hz_stall);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got=%0b exp=1", out_valid); end
        e = sb.pop_front();
        checks++;
        if (out_rs_data !== e.data || out_payload !== e.payload) begin
            errors++; $display("FAIL rf_data got=%h exp=%h", out_rs_data, e.data);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rf_cnt got=%0d exp=0", stall_cnt); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_fwd_priority;
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd5, 1'b1, 32'h11);
        set_src(1, 5'd6, 1'b1, 32'h22);
        set_fwd(0, 1'b1, 5'd5, 1'b1, 32'hAAAA);
        set_fwd(1, 1'b1, 5'd6, 1'b1, 32'hCCCC);
        set_fwd(2, 1'b1, 5'd5, 1'b1, 32'hBBBB);
        new_payload();
        e.data = {32'hCCCC, 32'hAAAA}; e.payload = in_payload; sb.push_back(e);
        tick();
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rs_data !== e.data || out_payload !== e.payload) begin
            errors++; $display("FAIL fwd_young got=%h exp=%h", out_rs_data, e.data);
        end
        // x0: a pending, not-ready write to x0 must neither forward nor stall.
        set_src(0, 5'd0, 1'b1, 32'h99);
        set_fwd(0, 1'b1, 5'd0, 1'b0, 32'hDEAD);
        new_payload();
        e.data = {32'hCCCC, 32'h0}; e.payload = in_payload; sb.push_back(e);
        #1;
        checks++;
        if (hz_stall !== 1'b0) begin errors++; $display("FAIL fwd_x0_stall got=%0b exp=0", hz_stall); end
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rs_data !== e.data || out_payload !== e.payload) begin
            errors++; $display("FAIL fwd_x0 got=%h exp=%h", out_rs_data, e.data);
        end
        tick();
    endtask

    task automatic test_stall;
        idle();
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        in_valid = 1'b1;
        set_src(0, 5'd5, 1'b1, 32'h11);
        set_src(1, 5'd0, 1'b0, 32'h22);
        // Younger EX not ready, older WB ready: EX still decides.
        set_fwd(0, 1'b1, 5'd5, 1'b0, 32'h55);
        set_fwd(2, 1'b1, 5'd5, 1'b1, 32'h77);
        new_payload();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (hz_stall !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_comb%0d got=%0b/%0b exp=1/0", i, hz_stall, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d got=%0b exp=0", i, out_valid); end
        end
        checks++;
        if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        fwd_rd_ready[0] = 1'b1;
        e.data = {32'h0, 32'h55}; e.payload = in_payload; sb.push_back(e);
        #1;
        checks++;
        if (hz_stall !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got=%0b/%0b exp=0/1", hz_stall, in_ready);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rs_data !== e.data || out_payload !== e.payload) begin
            errors++; $display("FAIL stall_capture got=%h exp=%h", out_rs_data, e.data);
        end
        // Same hazard on an unused operand: no stall, data still forwarded.
        fwd_rd_ready[0] = 1'b0;
        in_rs_use[0]    = 1'b0;
        new_payload();
        e.data = {32'h0, 32'h55}; e.payload = in_payload; sb.push_back(e);
        #1;
        checks++;
        if (hz_stall !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL nouse_stall got=%0b/%0b exp=0/1", hz_stall, in_ready);
        end
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rs_data !== e.data || stall_cnt !== 4'd3) begin
            errors++; $display("FAIL nouse_capture got=%h cnt=%0d exp=%h cnt=3", out_rs_data, stall_cnt, e.data);
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [CNT_W-1:0] cnt0;
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd7, 1'b1, 32'h1234);
        set_src(1, 5'd8, 1'b1, 32'h5678);
        new_payload();
        e.data = {32'h5678, 32'h1234}; e.payload = in_payload; sb.push_back(e);
        tick();
        cnt0 = stall_cnt;
        out_ready = 1'b0;
        set_src(0, 5'd9, 1'b1, 32'hAB);
        set_src(1, 5'd10, 1'b1, 32'hCD);
        new_payload();
        e.data = {32'hCD, 32'hAB}; e.payload = in_payload; sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%0b exp=0", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_rs_data !== sb[0].data || out_payload !== sb[0].payload
                || stall_cnt !== cnt0) begin
                errors++; $display("FAIL bp_hold%0d got=%h cnt=%0d exp=%h cnt=%0d", i, out_rs_data, stall_cnt, sb[0].data, cnt0);
            end
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_rs_data !== e.data || out_payload !== e.payload) begin
            errors++; $display("FAIL bp_next got=%h exp=%h", out_rs_data, e.data);
        end
        tick();
    endtask

    task automatic test_flush;
        logic [CNT_W-1:0] cnt0;
        idle();
        // Flush during a hazard stall.
        in_valid = 1'b1;
        set_src(0, 5'd3, 1'b1, 32'h1);
        set_fwd(0, 1'b1, 5'd3, 1'b0, 32'h2);
        cnt0 = stall_cnt;
        out_flush = 1'b1;
        #1;
        checks++;
        if (in_flush !== 1'b1 || hz_stall !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_stall_comb got=%0b/%0b/%0b exp=1/0/1", in_flush, hz_stall, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== cnt0) begin
            errors++; $display("FAIL flush_stall got=%0b cnt=%0d exp=0 cnt=%0d", out_valid, stall_cnt, cnt0);
        end
        // Flush during a hold.
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd4, 1'b1, 32'h44);
        new_payload();
        tick();
        out_ready = 1'b0;
        tick();
        out_flush = 1'b1;
        #1;
        checks++;
        if (in_flush !== 1'b1 || hz_stall !== 1'b0) begin
            errors++; $display("FAIL flush_hold_comb got=%0b/%0b exp=1/0", in_flush, hz_stall);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got=%0b exp=0", out_valid); end
        idle();
        tick();
    endtask

    task automatic test_counter;
        idle();
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        in_valid = 1'b1;
        set_src(1, 5'd12, 1'b1, 32'h0);
        set_fwd(1, 1'b1, 5'd12, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got=%0d exp=15", stall_cnt); end
        stall_cnt_clr = 1'b1;
        #1;
        checks++;
        if (hz_stall !== 1'b1) begin errors++; $display("FAIL cnt_clr_stall got=%0b exp=1", hz_stall); end
        tick();
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr got=%0d exp=0", stall_cnt); end
        stall_cnt_clr = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin errors++; $display("FAIL cnt_restart got=%0d exp=1", stall_cnt); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid;
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd2, 1'b1, 32'h0);
        set_fwd(0, 1'b1, 5'd2, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (stall_cnt !== 4'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_stall got=%0d/%0b exp=0/0", stall_cnt, out_valid);
        end
        idle();
        in_valid = 1'b1;
        set_src(0, 5'd2, 1'b1, 32'h5);
        tick();
        out_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold got=%0b exp=0", out_valid); end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_regfile();
        test_fwd_priority();
        test_stall();
        test_backpressure();
        test_flush();
        test_counter();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
